// File: rtl/pipe_pkg.sv
// Shared types and width helpers for the pipeline-stage register family.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned CTRL_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_DATA_DEF = 4;
  localparam int unsigned WSEL_W_DEF   = 3;

  // Packed entry layout, LSB first: ctrl, data channels, wsel, err.
  function automatic int unsigned payload_w(input int unsigned ctrl_w,
                                            input int unsigned num_data,
                                            input int unsigned data_w,
                                            input int unsigned wsel_w);
    return ctrl_w + num_data * data_w + wsel_w + 1;
  endfunction

  localparam int unsigned PAYLOAD_W_DEF =
      payload_w(CTRL_W_DEF, NUM_DATA_DEF, DATA_W_DEF, WSEL_W_DEF);

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the stage: a load-enabled register with async active-low clear.
module pipe_entry #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with a two-entry skid buffer, flush and error carry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = CTRL_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       NUM_DATA    = NUM_DATA_DEF,
  parameter int unsigned       WSEL_W      = WSEL_W_DEF,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [WSEL_W-1:0]          in_wsel,
  input  logic                       in_err,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [WSEL_W-1:0]          out_wsel,
  output logic                       out_err,
  output logic [1:0]                 occupancy
);

  localparam int unsigned PAYLOAD_W = payload_w(CTRL_W, NUM_DATA, DATA_W, WSEL_W);

  state_e               state_q;
  logic                 do_accept;
  logic                 do_release;
  logic                 main_load;
  logic                 skid_load;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] main_d;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;

  // Handshake decode depends on registered state only.
  assign in_ready   = (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign do_accept  = in_valid & in_ready;
  assign do_release = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (do_accept) state_q <= ONE;
        ONE: begin
          if (do_accept && !do_release) begin
            state_q <= TWO;
          end else if (!do_accept && do_release) begin
            state_q <= EMPTY;
          end
        end
        TWO:     if (do_release) state_q <= ONE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign in_payload = {in_err, in_wsel, in_data, in_ctrl};

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_payload;
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load = do_accept;
        ONE: begin
          main_load = do_accept & do_release;
          skid_load = do_accept & ~do_release;
        end
        TWO: begin
          main_load = do_release;
          main_d    = skid_q;
        end
        default: ;
      endcase
    end
  end

  pipe_entry #(
    .Width (PAYLOAD_W)
  ) u_main (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_entry #(
    .Width (PAYLOAD_W)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (skid_load),
    .d_i    (in_payload),
    .q_o    (skid_q)
  );

  assign out_ctrl = out_valid ? main_q[CTRL_W-1:0] : BUBBLE_CTRL;
  assign out_data = main_q[CTRL_W +: NUM_DATA*DATA_W];
  assign out_wsel = main_q[CTRL_W + NUM_DATA*DATA_W +: WSEL_W];
  assign out_err  = out_valid & main_q[PAYLOAD_W-1];

  always_comb begin
    unique case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: stimulus pushes accepted entries into a FIFO model, a monitor checks outputs.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_err, flush, out_valid, out_ready, out_err;
  logic [15:0] in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [2:0]  in_wsel, out_wsel;
  logic [1:0]  occupancy;

  logic        w_in_valid, w_in_ready, w_in_err, w_flush, w_out_valid, w_out_ready, w_out_err;
  logic [7:0]  w_in_ctrl, w_out_ctrl;
  logic [31:0] w_in_data, w_out_data;
  logic [2:0]  w_in_wsel, w_out_wsel;
  logic [1:0]  w_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] ctrl;
    logic [63:0] data;
    logic [2:0]  wsel;
    logic        err;
  } ent_t;

  ent_t exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_wsel   (in_wsel),
    .in_err    (in_err),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_wsel  (out_wsel),
    .out_err   (out_err),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(
    .CTRL_W   (8),
    .DATA_W   (32),
    .NUM_DATA (1),
    .WSEL_W   (3)
  ) u_dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_ctrl   (w_in_ctrl),
    .in_data   (w_in_data),
    .in_wsel   (w_in_wsel),
    .in_err    (w_in_err),
    .flush     (w_flush),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_ctrl  (w_out_ctrl),
    .out_data  (w_out_data),
    .out_wsel  (w_out_wsel),
    .out_err   (w_out_err),
    .occupancy (w_occupancy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_err"}, out_err, 1'b0);
    check({tag, "_occupancy"}, occupancy, 2'd0);
    check({tag, "_out_ctrl"}, out_ctrl, 16'h0000);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_data"}, out_data, 64'h0);
  endtask

  // Drive one cycle; the model sees the accept/flush after the monitor has handled release.
  task automatic cyc(input logic v, input logic [15:0] c, input logic [63:0] d,
                     input logic [2:0] w, input logic e, input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    in_wsel   = w;
    in_err    = e;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (rst && fl) begin
      exp_q.delete();
    end else if (rst && v && in_ready) begin
      exp_q.push_back('{ctrl: c, data: d, wsel: w, err: e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: the model is a plain FIFO; occupancy is its size, ready is size < 2.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("out_valid", out_valid, 1'b1);
      check("out_ctrl", out_ctrl, exp_q[0].ctrl);
      check("out_data", out_data, exp_q[0].data);
      check("out_wsel", out_wsel, exp_q[0].wsel);
      check("out_err", out_err, exp_q[0].err);
      if (rst && out_ready) void'(exp_q.pop_front());
    end else begin
      check("bubble_valid", out_valid, 1'b0);
      check("bubble_ctrl", out_ctrl, 16'h0000);
      check("bubble_err", out_err, 1'b0);
    end
    check("in_ready", in_ready, (exp_q.size() + ((rst && out_ready && out_valid) ? 1 : 0)) < 2);
    check("occupancy", occupancy,
          exp_q.size() + ((rst && out_ready && out_valid && exp_q.size() < 2) ? 1 : 0));
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_wsel = '0; in_err = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_ctrl = '0; w_in_data = '0; w_in_wsel = '0; w_in_err = 1'b0;
    w_flush = 1'b0; w_out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming at full throughput.
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, 16'h8000 + 16'(i), {$urandom, $urandom}, 3'(i), 1'b0, 1'b1, 1'b0);
    idle(2);

    // Downstream stall of three cycles while upstream keeps offering.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 16'h9000 + 16'(i), {$urandom, $urandom}, 3'(i), 1'b0,
          !(i >= 1 && i <= 3), 1'b0);
    idle(3);

    // Flush while two entries are held, with a simultaneous offer.
    cyc(1'b1, 16'hA001, 64'h1, 3'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hA002, 64'h2, 3'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hBAD0, 64'hBAD, 3'd7, 1'b0, 1'b0, 1'b1);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_occupancy", occupancy, 2'd0);
    check("flush_out_ctrl", out_ctrl, 16'h0000);
    idle(2);

    // Error bit rides with its own entry only.
    cyc(1'b1, 16'hC001, 64'h11, 3'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hC002, 64'h22, 3'd4, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Channel 3 only.
    cyc(1'b1, 16'hD001, {16'hFFFF, 48'h0}, 3'd5, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset while in TWO.
    cyc(1'b1, 16'hE001, 64'h33, 3'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hE002, 64'h44, 3'd2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    #1 rst = 1'b1;
    cyc(1'b1, 16'hE003, 64'h55, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), {$urandom, $urandom}, 3'($urandom),
          1'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    idle(4);

    // Alternate parameter set: single 32-bit channel, 8-bit control.
    w_out_ready = 1'b1;
    w_in_valid  = 1'b1;
    w_in_ctrl   = 8'h5A;
    w_in_data   = 32'hDEADBEEF;
    w_in_wsel   = 3'd6;
    w_in_err    = 1'b0;
    @(posedge clk);
    #1;
    check("w_valid0", w_out_valid, 1'b1);
    check("w_data0", w_out_data, 32'hDEADBEEF);
    check("w_ctrl0", w_out_ctrl, 8'h5A);
    check("w_wsel0", w_out_wsel, 3'd6);
    w_in_ctrl = 8'hC3;
    w_in_data = 32'h12345678;
    w_in_err  = 1'b1;
    @(posedge clk);
    #1;
    check("w_data1", w_out_data, 32'h12345678);
    check("w_ctrl1", w_out_ctrl, 8'hC3);
    check("w_err1", w_out_err, 1'b1);
    w_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w_valid2", w_out_valid, 1'b0);
    check("w_ctrl2", w_out_ctrl, 8'h00);
    check("w_err2", w_out_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
